// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Optional feature macro: MULDIV_DIV_EN (enables DIVU/REMU datapath).
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  // Divide-class ops use the restoring-divide step
  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIVU) || (o == OP_REMU);
  endfunction

  // Ops whose result lives in the upper register of the {hi, lo} pair
  function automatic logic op_sel_hi(input op_e o);
    return (o == OP_MULHU) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on the {hi, lo} pair.
// The add/subtract itself is done by the shared ALU; this block only forms its
// operands and consumes its result in the same cycle.
// Optional feature macro: MULDIV_DIV_EN (adds the divide step and compare).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic             is_div_i,
`endif
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic [WIDTH-1:0] hi_nxt_o,
  output logic [WIDTH-1:0] lo_nxt_o,
  output logic [WIDTH-1:0] alu_op1_o,
  output logic [WIDTH-1:0] alu_op2_o,
  output logic [3:0]       alu_fun_o
);

  logic [WIDTH-1:0] mul_sum;
  logic             mul_c;
`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] rem_sh;
  logic             take;
`endif

  // Next register pair and ALU request for the active op class
  always_comb begin
    // Multiply: conditional add of the multiplicand, carry recovered by compare
    mul_sum   = lo_i[0] ? alu_result_i : hi_i;
    mul_c     = lo_i[0] & (alu_result_i < hi_i);
    hi_nxt_o  = {mul_c, mul_sum[WIDTH-1:1]};
    lo_nxt_o  = {mul_sum[0], lo_i[WIDTH-1:1]};
    alu_op1_o = hi_i;
    alu_op2_o = opnd_i;
    alu_fun_o = ALU_ADD;
`ifdef MULDIV_DIV_EN
    // Divide: the bit shifted out of rem makes the partial remainder WIDTH+1 wide
    rem_sh = {hi_i[WIDTH-2:0], lo_i[WIDTH-1]};
    take   = hi_i[WIDTH-1] | (rem_sh >= opnd_i);
    if (is_div_i) begin
      alu_op1_o = rem_sh;
      alu_fun_o = ALU_SUB;
      hi_nxt_o  = take ? alu_result_i : rem_sh;
      lo_nxt_o  = {lo_i[WIDTH-2:0], take};
    end
`endif
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer borrowing the shared ALU
// for one add or subtract per cycle.
// Optional feature macro: MULDIV_DIV_EN (without it DIVU/REMU return 0 at once).
module alu_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [3:0]       alu_fun,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH-1:0] step_op1;
  logic [WIDTH-1:0] step_op2;
  logic [3:0]       step_fun;
  logic             calc_c;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
`ifdef MULDIV_DIV_EN
    .is_div_i     (op_is_div(op_q)),
`endif
    .hi_i         (hi_q),
    .lo_i         (lo_q),
    .opnd_i       (opnd_q),
    .alu_result_i (alu_result),
    .hi_nxt_o     (hi_d),
    .lo_nxt_o     (lo_d),
    .alu_op1_o    (step_op1),
    .alu_op2_o    (step_op2),
    .alu_fun_o    (step_fun)
  );

  // ALU operands are only presented while we own the ALU
  assign calc_c  = (state_q == ST_CALC);
  assign alu_op1 = calc_c ? step_op1 : '0;
  assign alu_op2 = calc_c ? step_op2 : '0;
  assign alu_fun = calc_c ? step_fun : ALU_ADD;

  assign busy    = busy_q;
  assign alu_req = busy_q;
  assign done    = done_q;
  assign result  = result_q;

  // Sequencer FSM, iteration counter, working registers and result register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op_e'(op);
            cnt_q <= '0;
`ifdef MULDIV_DIV_EN
            hi_q    <= '0;
            lo_q    <= a;
            opnd_q  <= b;
            busy_q  <= 1'b1;
            state_q <= ST_CALC;
`else
            if (op_is_div(op_e'(op))) begin
              result_q <= '0;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              hi_q    <= '0;
              lo_q    <= a;
              opnd_q  <= b;
              busy_q  <= 1'b1;
              state_q <= ST_CALC;
            end
`endif
          end
        end
        ST_CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_q <= op_sel_hi(op_q) ? hi_d : lo_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed cases plus random ops
// against an arithmetic reference model. Honours MULDIV_DIV_EN.
module tb_alu_muldiv_seq;

  localparam int unsigned W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          alu_req;
  logic [W-1:0]  alu_op1;
  logic [W-1:0]  alu_op2;
  logic [3:0]    alu_fun;
  logic [W-1:0]  alu_result;

  int checks   = 0;
  int failures = 0;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .alu_req    (alu_req),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_fun    (alu_fun),
    .alu_result (alu_result)
  );

  always #5 CLK = ~CLK;

  // Shared MCU ALU: add or subtract, combinational
  always_comb alu_result = (alu_fun == 4'b1000) ? (alu_op1 - alu_op2) : (alu_op1 + alu_op2);

  function automatic logic [W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    logic [63:0] p;
    p = 64'(x) * 64'(y);
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return !DIV_EN ? '0 : ((y == '0) ? '1 : x / y);
      default: return !DIV_EN ? '0 : ((y == '0) ? x : x % y);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, follow it to done, check latency/result/ALU usage
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit disturb, input string tag);
    logic [W-1:0] exp_res;
    bit           skip;
    int           exp_lat;
    logic [3:0]   exp_fun;
    int           k;
    int           done_k;
    int           busy_n;
    int           fun_bad;
    int           req_bad;
    exp_res = ref_model(o, x, y);
    skip    = !DIV_EN && o[1];
    exp_lat = skip ? 1 : W + 1;
    exp_fun = o[1] ? 4'b1000 : 4'b0000;
    done_k  = 0;
    busy_n  = 0;
    fun_bad = 0;
    req_bad = 0;
    @(negedge CLK);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    k = 1;
    while (k <= int'(W) + 8 && done_k == 0) begin
      if (busy) begin
        busy_n++;
        if (alu_fun !== exp_fun) fun_bad++;
      end
      if (alu_req !== busy) req_bad++;
      if (done) begin
        done_k = k;
      end else begin
        if (disturb && k == 5) begin
          start = 1'b1; op = ~o; a = 32'h0BAD_F00D; b = 32'd3;
        end
        if (disturb && k == 6) start = 1'b0;
        @(posedge CLK); #1;
        k++;
      end
    end
    check({tag, " done_latency"}, 64'(done_k), 64'(exp_lat));
    check({tag, " result"}, 64'(result), 64'(exp_res));
    check({tag, " busy_cycles"}, 64'(busy_n), skip ? 64'd0 : 64'(W));
    check({tag, " alu_fun_calc"}, 64'(fun_bad), 64'd0);
    check({tag, " alu_req_eq_busy"}, 64'(req_bad), 64'd0);
    if (disturb) begin
      start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    end
    @(posedge CLK); #1;
    start = 1'b0;
    check({tag, " done_one_cycle"}, 64'(done), 64'd0);
    @(posedge CLK); #1;
    check({tag, " idle_after_done"}, {62'd0, busy, done}, 64'd0);
    check({tag, " result_held"}, 64'(result), 64'(exp_res));
    check({tag, " alu_fun_idle"}, 64'(alu_fun), 64'd0);
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset busy_done_req", {61'd0, busy, done, alu_req}, 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset alu_ops", {alu_op1, alu_op2}, 64'd0);
    check("reset alu_fun", 64'(alu_fun), 64'd0);
    RST = 1'b0;

    run_op(2'b00, 32'd6, 32'd7, 1'b0, "mul_6x7");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhu_max");
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul_max");
    run_op(2'b10, 32'd100, 32'd7, 1'b0, "divu_100_7");
    run_op(2'b11, 32'd100, 32'd7, 1'b0, "remu_100_7");
    run_op(2'b10, 32'h8000_0000, 32'd3, 1'b0, "divu_msb_3");
    run_op(2'b10, 32'd5, 32'd0, 1'b0, "divu_by0");
    run_op(2'b11, 32'd5, 32'd0, 1'b0, "remu_by0");
    run_op(2'b00, 32'd1234, 32'd5678, 1'b1, "mul_start_ignored");
    run_op(2'b11, 32'hDEAD_BEEF, 32'd1000, 1'b1, "remu_start_ignored");

    // Reset in the middle of a multiply
    run_op(2'b00, 32'd11, 32'd13, 1'b0, "mul_pre_reset");
    @(negedge CLK);
    op = 2'b00; a = 32'd77; b = 32'd99; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    check("midrst busy_before", 64'(busy), 64'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("midrst busy_done_req", {61'd0, busy, done, alu_req}, 64'd0);
    check("midrst result", 64'(result), 64'd0);
    check("midrst alu_fun_ops", {28'd0, alu_fun, alu_op1}, 64'd0);
    repeat (W + 4) begin
      @(posedge CLK); #1;
      if (done) check("midrst no_done", 64'(done), 64'd0);
    end
    check("midrst still_idle", {62'd0, busy, done}, 64'd0);
    run_op(2'b00, 32'd3, 32'd5, 1'b0, "mul_after_reset");

    // Random ops, with zero and small divisors mixed in
    for (int i = 0; i < 24; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 16));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 1'b0, $sformatf("rand%0d_op%0d", i, ro));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle sequencer that implements RV32M-style unsigned multiply and divide (MUL, MULHU, DIVU, REMU) by borrowing the MCU's shared 32-bit ALU for one add or subtract per cycle. It sits beside the execute stage. While busy it asserts `alu_req` so the ALU operand mux selects its `alu_op1`/`alu_op2`/`alu_fun`, and it returns a registered result with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 32: operand and result width; the iteration count equals `WIDTH`.
- `CLK`  in  1: rising-edge clock.
- `RST`  in  1: synchronous, active-high reset.
- `start`  in  1: request. Sampled only in IDLE.
- `op`  in  2: operation select. 00 = MUL, 01 = MULHU, 10 = DIVU, 11 = REMU.
- `a`, `b`  in  WIDTH: operands. Multiplier/multiplicand, or dividend/divisor.
- `busy`  out  1: high in CALC.
- `done`  out  1: one-cycle pulse in DONE.
- `result`  out  WIDTH: registered; held until the next accepted start.
- `alu_req`  out  1: ALU ownership request. Equal to `busy`.
- `alu_op1`, `alu_op2`  out  WIDTH: ALU operands.
- `alu_fun`  out  4: ADD = 4'b0000, SUB = 4'b1000. Drives 4'b0000 when idle.
- `alu_result`  in  WIDTH: combinational ALU output for the current cycle.

## Operation
- **States:** IDLE → CALC → DONE → IDLE.
- **IDLE:**
  - When `start` is high, latch `op`, `a` and `b`, clear the iteration counter, and enter CALC.
  - MUL/MULHU: `acc_hi` = 0, `acc_lo` = `a`, `mcand` = `b`.
  - DIVU/REMU: `rem` = 0, `quo` = `a`, `dvsr` = `b`.
- **CALC, MUL/MULHU:** each cycle drives `alu_op1` = `acc_hi`, `alu_op2` = `mcand`, ADD.
  - If `acc_lo[0]`: `sum` = `alu_result` and `c` = (`alu_result` < `acc_hi`, unsigned). Otherwise `sum` = `acc_hi` and `c` = 0.
  - Update {`acc_hi`,`acc_lo`} ← {`c`, `sum`, `acc_lo[WIDTH-1:1]`}.
- **CALC, DIVU/REMU:** `rem_sh` = {`rem[WIDTH-2:0]`, `quo[WIDTH-1]`}, `hi` = `rem[WIDTH-1]`. Each cycle drives `alu_op1` = `rem_sh`, `alu_op2` = `dvsr`, SUB.
  - If `hi` or `rem_sh` ≥ `dvsr`: `rem` ← `alu_result`, `quo` ← {`quo[WIDTH-2:0]`, 1}.
  - Otherwise: `rem` ← `rem_sh`, `quo` ← {`quo[WIDTH-2:0]`, 0}.
- **End of CALC:** after `WIDTH` iterations, `result` is loaded on the same edge that enters DONE.
  - MUL → `acc_lo`; MULHU → `acc_hi`; DIVU → `quo`; REMU → `rem`.
- **Divide by zero:** no special case. The algorithm naturally yields DIVU = all ones and REMU = `a`, matching RISC-V.
- **DONE:** `done` = 1 for one cycle, then IDLE unconditionally.
- **`start` outside IDLE:** ignored. This includes a `start` in DONE, so the earliest next acceptance is the cycle after DONE.
- **Operand hold:** `a`, `b` and `op` need only be valid in the start cycle.

## Timing
- **Reset:** state IDLE, `busy` = 0, `done` = 0, `alu_req` = 0, `result` = 0, `alu_op1`/`alu_op2` = 0, `alu_fun` = 4'b0000, counter = 0.
- **Reset mid-operation:** abandons the computation with no `done`. `result` returns to 0.
- **Latency:** `start` sampled at edge E.
  - `busy`/`alu_req` high in cycles E+1 … E+WIDTH.
  - `done` high in cycle E+WIDTH+1 (E+33 for WIDTH = 32).
  - `result` is valid from cycle E+WIDTH+1.
- **ALU path:** `alu_op*` and `alu_fun` are combinational from state registers. `alu_result` is consumed in the same cycle, so there is a single-cycle ALU path.
- **Counter:** width `$clog2(WIDTH)+1`. It wraps to 0 on entering IDLE.
- **Throughput:** one operation per WIDTH+2 cycles.

## Configuration
- **With `MULDIV_DIV_EN` defined:** all four ops are implemented as above.
- **Without `MULDIV_DIV_EN`:**
  - DIVU/REMU skip CALC. IDLE → DONE directly, with `done` in cycle E+1, `result` = 0, and `busy`/`alu_req` never asserted.
  - The `rem`/`quo`/`dvsr` registers and the compare logic are removed.
  - MUL/MULHU are unchanged.

## Structure
- **Shared package `muldiv_pkg`:**
  - `typedef enum logic [1:0]` for `op`: MUL, MULHU, DIVU, REMU.
  - State enum: IDLE, CALC, DONE.
  - ALU function constants: `ALU_ADD` = 4'b0000, `ALU_SUB` = 4'b1000.
- **Sub-module:** one, `muldiv_step`. It is combinational and computes the next {hi, lo} register pair and the ALU operand/function for the current op class. The top keeps the FSM, counter and result register.

## Test plan
- MUL `a` = 6, `b` = 7 → `done` at E+33, `result` = 42. `alu_fun` = 4'b0000 throughout CALC.
- MULHU `a` = `b` = 32'hFFFFFFFF → `result` = 32'hFFFFFFFE. A MUL on the same operands gives 32'h00000001.
- DIVU 100/7 → 14. REMU 100/7 → 2. DIVU 32'h80000000/3 → 32'h2AAAAAAA. `alu_fun` = 4'b1000 in CALC.
- DIVU 5/0 → 32'hFFFFFFFF. REMU 5/0 → 5.
- `start` pulses with different operands during CALC and during DONE → ignored; exactly one `done`, with the original result.
- `RST` at E+10 of a MUL → next cycle IDLE, `busy` = 0, `result` = 0, no `done`. A new MUL 3×5 then returns 15.
- With the macro undefined: DIVU 100/7 → `done` at E+1, `result` = 0, `alu_req` never high.
